aidan_mcnay_spi_frame_rx: RTL and testbench
===========================================

// Module: aidan_mcnay_spi_frame_rx
// PURPOSE
//  SPI-style serial receiver that sits directly upstream of the prime detector's operand input.
//  - Samples async SCLK/SDI/CS_n pins and assembles one nbits-wide word per CS_n frame, MSB first.
//  - Delivers the word on a val/rdy stream and flags malformed or overrun frames.
//  - Replaces the free-running shift register with a length-checked frame interface.
// PARAMETERS
//  nbits  31  word width; a frame is valid only with exactly nbits SCLK rising edges while CS_n is low
// PORTS
//  clk        in   1      system clock; all state on posedge
//  reset      in   1      asynchronous, active-low reset
//  sclk_in    in   1      async serial clock pin (already debounced externally)
//  sdi_in     in   1      async serial data pin
//  cs_n_in    in   1      async chip select, active low; one frame per low period
//  out_data   out  nbits  received word; stable while out_val=1
//  out_val    out  1      word available
//  out_rdy    in   1      consumer accepts; transfer when out_val & out_rdy at posedge
//  frame_err  out  1      1-cycle pulse: frame ended with bit count != nbits
//  overrun    out  1      1-cycle pulse: good frame dropped because previous word not taken
//  busy       out  1      1 while FSM in SHIFT
// BEHAVIOUR
//  Reset (reset=0, async): sync flops sclk=0, sdi=0, cs_n=1; shreg=0, cnt=0, too_long=0.
//   Outputs on reset: out_data=0, out_val=0, frame_err=0, overrun=0, busy=0, state=IDLE.
//  Sync: 2-flop synchroniser on each pin -> sclk_s, sdi_s, cs_s.
//   sclk_q = sclk_s delayed 1 cycle; rise = sclk_s & ~sclk_q.
//   SCLK high and low phases must each be >= 3 clk periods; shorter pulses are unsupported.
//  Counter: cnt is $clog2(nbits+1) bits and saturates at nbits; too_long is a sticky flag.
//  FSM (2 states):
//   IDLE: if cs_s==0 -> SHIFT; shreg<=0, cnt<=0, too_long<=0.
//   SHIFT, cs_s==0, rise=1:
//    - cnt<nbits: shreg<={shreg[nbits-2:0],sdi_s}; cnt<=cnt+1.
//    - cnt==nbits: too_long<=1; shreg unchanged.
//   SHIFT, cs_s==1 (end of frame) -> IDLE. A rise in the same cycle is ignored (CS wins).
//    - good frame (cnt==nbits & ~too_long):
//      - out_val==0, or out_val & out_rdy this cycle: out_data<=shreg, out_val<=1.
//      - else: overrun<=1 for 1 cycle; out_data/out_val unchanged.
//    - bad frame: frame_err<=1 for 1 cycle. Zero-bit frames count as bad.
//  Stream:
//   - out_val falls the cycle after out_val & out_rdy, unless a good frame loads in the same cycle.
//   - A same-cycle reload keeps out_val=1 with the new data and raises no overrun.
//   - out_data never changes while out_val=1 without a transfer.
//  Latency: cs_n_in rises before edge k -> out_val/frame_err/overrun registered at edge k+2 (3 clk).
//  Reception continues while a word is pending (separate shreg and output register).
//  Reset asserted mid-frame or mid-hold: everything clears immediately; a partial frame is lost.
//   After release the FSM waits in IDLE for cs_s==0, so a frame cut by reset is not resumed.
//  busy=1 exactly while state==SHIFT.
// TESTING
//  1. nbits=31, send 31'd97 MSB-first, out_rdy=1 -> out_val 1 cycle, out_data=97, no err.
//  2. Frame with 30 edges, then frame with 32 edges -> frame_err pulse each, out_val stays 0.
//  3. out_rdy=0; frames 13 then 17 -> out_data=13 held, overrun pulse on 2nd.
//     Then out_rdy=1 -> 13 transferred, out_val=0.
//  4. out_val=1 (word 5), out_rdy pulsed in the CS_n-rise-processing cycle of frame 7.
//     -> out_data=7, out_val stays 1, overrun=0.
//  5. reset=0 after 15 bits of a frame, released with CS_n still low.
//     -> outputs 0 immediately; remaining bits start a new frame -> frame_err at CS_n rise.
//  6. Back-to-back 31'h7FFFFFFF then 31'd2 with 4-cycle CS_n gap -> two correct words, in order.

Source files
------------

// File: rtl/aidan_mcnay_spi_frame_rx.sv
// SPI-style frame receiver: synchronises SCLK/SDI/CS_n, shifts one MSB-first word per
// CS_n low period and hands it to a val/rdy consumer, flagging bad-length and overrun frames.
module aidan_mcnay_spi_frame_rx #(
  parameter int nbits = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk_in,
  input  logic             sdi_in,
  input  logic             cs_n_in,
  output logic [nbits-1:0] out_data,
  output logic             out_val,
  input  logic             out_rdy,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = $clog2(nbits + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(nbits);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t state_q, state_d;

  logic sclk_m_q, sclk_s_q, sclk_dly_q;
  logic sdi_m_q, sdi_s_q;
  logic cs_m_q, cs_s_q;
  logic rise;

  logic [nbits-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             too_long_q, too_long_d;
  logic [nbits-1:0] out_data_q, out_data_d;
  logic             out_val_q, out_val_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             good_frame;

  // Two-flop synchronisers; CS_n idles high so its chain resets to 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_m_q   <= 1'b0;
      sclk_s_q   <= 1'b0;
      sclk_dly_q <= 1'b0;
      sdi_m_q    <= 1'b0;
      sdi_s_q    <= 1'b0;
      cs_m_q     <= 1'b1;
      cs_s_q     <= 1'b1;
    end else begin
      sclk_m_q   <= sclk_in;
      sclk_s_q   <= sclk_m_q;
      sclk_dly_q <= sclk_s_q;
      sdi_m_q    <= sdi_in;
      sdi_s_q    <= sdi_m_q;
      cs_m_q     <= cs_n_in;
      cs_s_q     <= cs_m_q;
    end
  end

  assign rise       = sclk_s_q & ~sclk_dly_q;
  assign good_frame = (cnt_q == CNT_MAX) & ~too_long_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (!cs_s_q) state_d = SHIFT;
    end else begin
      if (cs_s_q) state_d = IDLE;
    end
  end

  always_comb begin
    busy = (state_q == SHIFT);
  end

  always_comb begin
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    too_long_d  = too_long_q;
    out_data_d  = out_data_q;
    out_val_d   = out_val_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    if (out_val_q && out_rdy) out_val_d = 1'b0;
    if (state_q == IDLE) begin
      if (!cs_s_q) begin
        shreg_d    = '0;
        cnt_d      = '0;
        too_long_d = 1'b0;
      end
    end else if (cs_s_q) begin
      // End of frame takes priority over any coincident SCLK rise.
      if (good_frame) begin
        if (!out_val_q || out_rdy) begin
          out_data_d = shreg_q;
          out_val_d  = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        frame_err_d = 1'b1;
      end
    end else if (rise) begin
      if (cnt_q != CNT_MAX) begin
        shreg_d = {shreg_q[nbits-2:0], sdi_s_q};
        cnt_d   = cnt_q + 1'b1;
      end else begin
        too_long_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q     <= '0;
      cnt_q       <= '0;
      too_long_q  <= 1'b0;
      out_data_q  <= '0;
      out_val_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      too_long_q  <= too_long_d;
      out_data_q  <= out_data_d;
      out_val_q   <= out_val_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_val   = out_val_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_aidan_mcnay_spi_frame_rx.sv
// Directed bench for aidan_mcnay_spi_frame_rx: pin-level SPI frames with hand-computed
// expectations; a negedge monitor records transfers and pulse cycles.
module tb_aidan_mcnay_spi_frame_rx;

  localparam int NB = 31;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sclk_in = 1'b0;
  logic          sdi_in = 1'b0;
  logic          cs_n_in = 1'b1;
  logic [NB-1:0] out_data;
  logic          out_val;
  logic          out_rdy = 1'b0;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int val_cycles = 0;
  int fe_cycles = 0;
  int ov_cycles = 0;
  logic [NB-1:0] rx_q[$];

  aidan_mcnay_spi_frame_rx #(.nbits(NB)) dut (
    .clk(clk), .reset(reset), .sclk_in(sclk_in), .sdi_in(sdi_in), .cs_n_in(cs_n_in),
    .out_data(out_data), .out_val(out_val), .out_rdy(out_rdy),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      if (out_val) val_cycles++;
      if (out_val && out_rdy) rx_q.push_back(out_data);
      if (frame_err) fe_cycles++;
      if (overrun) ov_cycles++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    val_cycles = 0;
    fe_cycles = 0;
    ov_cycles = 0;
    rx_q.delete();
  endtask

  task automatic cs_low();
    cs_n_in = 1'b0;
    tick(4);
  endtask

  task automatic send_bit(input logic b);
    sdi_in = b;
    tick(3);
    sclk_in = 1'b1;
    tick(3);
    sclk_in = 1'b0;
  endtask

  task automatic send_bits(input logic [NB-1:0] w, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      if (i < NB) send_bit(w[NB-1-i]);
      else        send_bit(1'b0);
    end
  endtask

  // Leaves CS_n just raised, one cycle ahead of the next active edge.
  task automatic send_frame(input logic [NB-1:0] w, input int n);
    cs_low();
    send_bits(w, 0, n);
    tick(3);
    cs_n_in = 1'b1;
  endtask

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic test_reset();
    tick(2);
    checks++;
    if (out_val !== 1'b0 || out_data !== '0 || frame_err !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: val=%b data=%0h fe=%b ov=%b busy=%b expected all zero",
               out_val, out_data, frame_err, overrun, busy);
    end
    reset = 1'b1;
    tick(3);
    $display("test_reset: out_val=%b busy=%b", out_val, busy);
  endtask

  task automatic test_single_word();
    clear_mon();
    out_rdy = 1'b1;
    send_frame(31'd97, NB);
    tick(2);
    chk("latency_not_early", {30'd0, out_val}, 31'd0);
    tick(1);
    chk("latency_val", {30'd0, out_val}, 31'd1);
    chk("latency_data", out_data, 31'd97);
    tick(6);
    chk("single_val_cycles", 31'(val_cycles), 31'd1);
    chk("single_rx_count", 31'(rx_q.size()), 31'd1);
    if (rx_q.size() > 0) chk("single_rx_word", rx_q[0], 31'd97);
    chk("single_no_err", 31'(fe_cycles + ov_cycles), 31'd0);
    $display("test_single_word: words=%0d fe=%0d ov=%0d", rx_q.size(), fe_cycles, ov_cycles);
  endtask

  task automatic test_bad_length();
    clear_mon();
    out_rdy = 1'b1;
    send_frame(31'h1234567, 30);
    tick(6);
    chk("short_frame_err", 31'(fe_cycles), 31'd1);
    send_frame(31'h1234567, 32);
    tick(6);
    chk("long_frame_err", 31'(fe_cycles), 31'd2);
    chk("bad_no_val", 31'(val_cycles), 31'd0);
    chk("bad_no_overrun", 31'(ov_cycles), 31'd0);
    $display("test_bad_length: fe=%0d val_cycles=%0d", fe_cycles, val_cycles);
  endtask

  task automatic test_overrun();
    clear_mon();
    out_rdy = 1'b0;
    send_frame(31'd13, NB);
    tick(6);
    send_frame(31'd17, NB);
    tick(6);
    chk("ovr_held_val", {30'd0, out_val}, 31'd1);
    chk("ovr_held_data", out_data, 31'd13);
    chk("ovr_pulse", 31'(ov_cycles), 31'd1);
    chk("ovr_no_fe", 31'(fe_cycles), 31'd0);
    out_rdy = 1'b1;
    tick(1);
    out_rdy = 1'b0;
    chk("ovr_drained_val", {30'd0, out_val}, 31'd0);
    chk("ovr_rx_count", 31'(rx_q.size()), 31'd1);
    if (rx_q.size() > 0) chk("ovr_rx_word", rx_q[0], 31'd13);
    $display("test_overrun: ov=%0d words=%0d", ov_cycles, rx_q.size());
  endtask

  task automatic test_same_cycle_reload();
    clear_mon();
    out_rdy = 1'b0;
    send_frame(31'd5, NB);
    tick(6);
    chk("reload_pending5", out_data, 31'd5);
    send_frame(31'd7, NB);
    tick(2);
    out_rdy = 1'b1;
    tick(1);
    out_rdy = 1'b0;
    chk("reload_val", {30'd0, out_val}, 31'd1);
    chk("reload_data", out_data, 31'd7);
    tick(3);
    chk("reload_hold_data", out_data, 31'd7);
    chk("reload_no_ovr", 31'(ov_cycles), 31'd0);
    chk("reload_rx_count", 31'(rx_q.size()), 31'd1);
    if (rx_q.size() > 0) chk("reload_rx_word", rx_q[0], 31'd5);
    out_rdy = 1'b1;
    tick(1);
    out_rdy = 1'b0;
    chk("reload_drained", {30'd0, out_val}, 31'd0);
    $display("test_same_cycle_reload: data=%0d ov=%0d", out_data, ov_cycles);
  endtask

  task automatic test_reset_midframe();
    out_rdy = 1'b0;
    send_frame(31'd9, NB);
    tick(6);
    chk("mid_pending", out_data, 31'd9);
    cs_low();
    send_bits(31'h5555555, 0, 15);
    reset = 1'b0;
    #1;
    checks++;
    if (out_val !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_clear: val=%b data=%0h busy=%b expected 0 0 0", out_val, out_data, busy);
    end
    tick(2);
    reset = 1'b1;
    clear_mon();
    tick(4);
    chk("mid_new_frame_busy", {30'd0, busy}, 31'd1);
    send_bits(31'h5555555, 15, 16);
    tick(3);
    cs_n_in = 1'b1;
    tick(6);
    chk("mid_frame_err", 31'(fe_cycles), 31'd1);
    chk("mid_no_val", 31'(val_cycles), 31'd0);
    chk("mid_no_ovr", 31'(ov_cycles), 31'd0);
    $display("test_reset_midframe: fe=%0d val_cycles=%0d", fe_cycles, val_cycles);
  endtask

  task automatic test_back_to_back();
    clear_mon();
    out_rdy = 1'b1;
    send_frame(31'h7FFFFFFF, NB);
    tick(4);
    send_frame(31'd2, NB);
    tick(6);
    chk("b2b_count", 31'(rx_q.size()), 31'd2);
    if (rx_q.size() > 1) begin
      chk("b2b_first", rx_q[0], 31'h7FFFFFFF);
      chk("b2b_second", rx_q[1], 31'd2);
    end
    chk("b2b_no_err", 31'(fe_cycles + ov_cycles), 31'd0);
    chk("b2b_idle", {30'd0, busy}, 31'd0);
    $display("test_back_to_back: words=%0d", rx_q.size());
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_bad_length();
    test_overrun();
    test_same_cycle_reload();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
